// File: rtl/apb_master_bridge.sv
// Request-to-APB master bridge: queues valid/ready requests in a small FIFO and
// replays each as a SETUP/ACCESS transfer, returning one response per request.
//
// state  | meaning
// IDLE   | bus idle, waiting for a queued request
// SETUP  | psel high, penable low, address phase (one cycle)
// ACCESS | psel and penable high, waiting for pready or timeout
module apb_master_bridge #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rnw_i,
    input  logic [9:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_timeout_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic [9:0]  paddr_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + 10 + 32;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic          full, empty, push, pop;
    logic          done, abort;
    logic [CW-1:0] wait_cnt;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready_o = ~full;
    assign push        = req_valid_i & ~full;
    assign head        = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {req_rnw_i, req_addr_i, req_wdata_i};
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    done = 1'b1;
                end else if (TO_EN && (wait_cnt == TO_LAST_C)) begin
                    abort = 1'b1;
                end
                // Chaining straight into SETUP drops penable for one cycle between transfers.
                if (done || abort) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wait_cnt      <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            paddr_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pwrite_o <= ~head[EW-1];
                paddr_o  <= head[41:32];
                pwdata_o <= head[31:0];
            end
            psel_o    <= (state_nxt != IDLE);
            penable_o <= (state_nxt == ACCESS);
            wait_cnt  <= ((state == ACCESS) && (state_nxt == ACCESS)) ? wait_cnt + 1'b1 : '0;
            rsp_valid_o   <= done | abort;
            rsp_timeout_o <= abort;
            rsp_rdata_o   <= (done && !pwrite_o) ? prdata_i : '0;
        end
    end

endmodule
